// File: rtl/axis_frame_fifo_pkg.sv
// Shared types and widths for the store-and-forward frame FIFO.
package axis_frame_fifo_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int STAT_W      = 32;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic                   last;
    } axis_beat_t;

endpackage

// File: rtl/axis_frame_fifo_sdp_ram.sv
// sdp_ram: simple dual-port RAM, one synchronous write port and one registered read port.
// Read data appears the cycle after rd_en and holds until the next read.
module sdp_ram #(
    parameter int  WIDTH = 33,
    parameter int  DEPTH = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXIS frame FIFO; frames that would overflow are dropped whole (FRAME_FIFO_STATS_EN adds counters).
// Latency: tlast accepted in cycle N -> first beat of that frame valid on egress in cycle N+2.
// Backpressure: s_axis_tready stays high outside reset; egress stalls through a 2-entry output skid.
module axis_frame_fifo
    import axis_frame_fifo_pkg::*;
#(
    parameter int  DATA_W = AXIS_DATA_W,
    parameter int  DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              drop_pulse
`ifdef FRAME_FIFO_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_frames_ok,
    output logic [STAT_W-1:0] stat_frames_drop
`endif
);

    localparam int              PTR_W   = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_commit;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] used;
    logic             drop_flag;
    logic             rdy_q;
    logic             in_beat;
    logic             full;
    logic             dropping;
    logic             wr_en;

    logic [DATA_W:0]  ram_rd_dat;
    logic [DATA_W:0]  skid0;
    logic [DATA_W:0]  skid1;
    logic [DATA_W:0]  head;
    logic [1:0]       skid_cnt;
    logic [1:0]       occ_after_pop;
    logic             rd_inflight;
    logic             rd_en;
    logic             out_vld;
    logic             out_pop;

    // ---------------- ingress ----------------
    assign s_axis_tready = rdy_q & ~rst;
    assign in_beat       = s_axis_tvalid & s_axis_tready;
    assign used          = wr_ptr - rd_ptr;
    assign full          = (used == DEPTH_P);
    assign dropping      = drop_flag | full;
    assign wr_en         = in_beat & ~dropping;
    assign drop_pulse    = in_beat & dropping & s_axis_tlast;

    // A dropped frame rewinds to the last commit point, discarding its already-stored beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q     <= 1'b0;
            wr_ptr    <= '0;
            wr_commit <= '0;
            drop_flag <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (s_axis_tlast) begin
                    wr_commit <= wr_ptr + 1'b1;
                end
            end else if (in_beat) begin
                if (s_axis_tlast) begin
                    wr_ptr    <= wr_commit;
                    drop_flag <= 1'b0;
                end else begin
                    drop_flag <= 1'b1;
                end
            end
        end
    end

    sdp_ram #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_dat  ({s_axis_tlast, s_axis_tdata}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_dat  (ram_rd_dat)
    );

    // ---------------- egress ----------------
    // The in-flight RAM word is presented directly when the skid is empty, giving N+2 latency.
    assign out_vld       = (skid_cnt != 2'd0) | rd_inflight;
    assign head          = (skid_cnt != 2'd0) ? skid0 : ram_rd_dat;
    assign out_pop       = out_vld & m_axis_tready;
    assign occ_after_pop = skid_cnt + {1'b0, rd_inflight} - {1'b0, out_pop};
    assign rd_en         = (rd_ptr != wr_commit) && (occ_after_pop < 2'd2);

    assign m_axis_tvalid = out_vld;
    assign m_axis_tdata  = out_vld ? head[DATA_W-1:0] : '0;
    assign m_axis_tlast  = out_vld & head[DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            rd_inflight <= 1'b0;
            skid_cnt    <= 2'd0;
            skid0       <= '0;
            skid1       <= '0;
        end else begin
            rd_inflight <= rd_en;
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (skid_cnt)
                2'd0: begin
                    if (rd_inflight && !out_pop) begin
                        skid0    <= ram_rd_dat;
                        skid_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (out_pop) begin
                        if (rd_inflight) begin
                            skid0 <= ram_rd_dat;
                        end else begin
                            skid_cnt <= 2'd0;
                        end
                    end else if (rd_inflight) begin
                        skid1    <= ram_rd_dat;
                        skid_cnt <= 2'd2;
                    end
                end
                default: begin
                    if (out_pop) begin
                        skid0 <= skid1;
                        if (rd_inflight) begin
                            skid1 <= ram_rd_dat;
                        end else begin
                            skid_cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef FRAME_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames_ok   <= '0;
            stat_frames_drop <= '0;
        end else begin
            if (wr_en && s_axis_tlast) begin
                stat_frames_ok <= stat_frames_ok + 1'b1;
            end
            if (drop_pulse) begin
                stat_frames_drop <= stat_frames_drop + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Directed bench for axis_frame_fifo: scoreboard queue of expected egress beats plus literal checks.
module tb_axis_frame_fifo;
    import axis_frame_fifo_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          drop_pulse;
`ifdef FRAME_FIFO_STATS_EN
    logic [STAT_W-1:0] stat_frames_ok;
    logic [STAT_W-1:0] stat_frames_drop;
`endif

    always #5 clk = ~clk;

    axis_frame_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .drop_pulse    (drop_pulse)
`ifdef FRAME_FIFO_STATS_EN
        ,
        .stat_frames_ok   (stat_frames_ok),
        .stat_frames_drop (stat_frames_drop)
`endif
    );

    axis_beat_t  exp_q[$];
    int          n_checks   = 0;
    int          n_fail     = 0;
    int          out_beats  = 0;
    int          drops_seen = 0;
    bit          check_en   = 1'b0;
    bit          cur_drop_exp = 1'b0;
    bit          hold_pend  = 1'b0;
    logic [DW:0] hold_val;
    logic [DW:0] last_out;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Per-cycle compare: egress beats against the scoreboard, AXIS hold rule, drop_pulse, ingress ready.
    always @(negedge clk) begin : cmp_blk
        axis_beat_t e;
        logic       exp_dp;
        if (rst || !check_en) begin
            hold_pend = 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                chk(exp_q.size() != 0, "egress_unexpected", {m_axis_tlast, m_axis_tdata}, 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk({m_axis_tlast, m_axis_tdata} == {e.last, e.data}, "egress_beat",
                        {m_axis_tlast, m_axis_tdata}, {e.last, e.data});
                end
                out_beats++;
                last_out = {m_axis_tlast, m_axis_tdata};
            end
            if (hold_pend) begin
                chk(m_axis_tvalid && ({m_axis_tlast, m_axis_tdata} == hold_val), "egress_hold",
                    {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, hold_val});
            end
            hold_pend = m_axis_tvalid && !m_axis_tready;
            hold_val  = {m_axis_tlast, m_axis_tdata};
            exp_dp = s_axis_tvalid && s_axis_tlast && cur_drop_exp;
            chk(drop_pulse == exp_dp, "drop_pulse", drop_pulse, exp_dp);
            if (drop_pulse) drops_seen++;
            if (s_axis_tvalid) chk(s_axis_tready == 1'b1, "s_tready", s_axis_tready, 1);
        end
    end

    task automatic send_frame(input int n, input logic [DW-1:0] base, input bit drop);
        axis_beat_t b;
        cur_drop_exp = drop;
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + DW'(i);
            s_axis_tlast  = (i == n - 1);
            if (!drop) begin
                b.data = base + DW'(i);
                b.last = (i == n - 1);
                exp_q.push_back(b);
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk(exp_q.size() == 0 && !m_axis_tvalid, name, exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk(m_axis_tvalid == 1'b0, {tag, "_m_tvalid"}, m_axis_tvalid, 0);
        chk(m_axis_tdata == '0,    {tag, "_m_tdata"},  m_axis_tdata, 0);
        chk(m_axis_tlast == 1'b0,  {tag, "_m_tlast"},  m_axis_tlast, 0);
        chk(drop_pulse == 1'b0,    {tag, "_drop"},     drop_pulse, 0);
        chk(s_axis_tready == 1'b0, {tag, "_s_tready"}, s_axis_tready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int d0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk(s_axis_tready == 1'b1, "ready_after_reset", s_axis_tready, 1);
        check_en = 1'b1;

        // 1: single 4-beat frame, first beat two cycles after tlast
        m_axis_tready = 1'b1;
        base = out_beats;
        send_frame(4, 32'h11, 1'b0);
        chk(m_axis_tvalid == 1'b0, "t1_valid_n1", m_axis_tvalid, 0);
        @(posedge clk); #1;
        chk(m_axis_tvalid == 1'b1, "t1_valid_n2", m_axis_tvalid, 1);
        chk(m_axis_tdata == 32'h11, "t1_first_data", m_axis_tdata, 32'h11);
        wait_drain(20, "t1_drain");
        chk(out_beats - base == 4, "t1_count", out_beats - base, 4);
        chk(last_out == {1'b1, 32'h14}, "t1_last", last_out, {1'b1, 32'h14});

        // 2: egress stalled; skid prefetch frees two RAM slots, so a 5-beat second frame overflows
        m_axis_tready = 1'b0;
        base = out_beats;
        d0 = drops_seen;
        send_frame(6, 32'h20, 1'b0);
        send_frame(5, 32'h30, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk(drops_seen - d0 == 1, "t2_drop_count", drops_seen - d0, 1);
        chk(out_beats == base, "t2_stalled", out_beats - base, 0);
        chk(m_axis_tvalid && m_axis_tdata == 32'h20, "t2_head_held", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'h20});
        m_axis_tready = 1'b1;
        wait_drain(30, "t2_drain");
        chk(out_beats - base == 6, "t2_count", out_beats - base, 6);
        chk(last_out == {1'b1, 32'h25}, "t2_last", last_out, {1'b1, 32'h25});

        // 3: oversize frame dropped, exactly-DEPTH frame accepted
        base = out_beats;
        d0 = drops_seen;
        send_frame(9, 32'h40, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk(drops_seen - d0 == 1, "t3_drop_count", drops_seen - d0, 1);
        chk(out_beats == base, "t3_no_egress", out_beats - base, 0);
        chk(m_axis_tvalid == 1'b0, "t3_idle", m_axis_tvalid, 0);
        send_frame(8, 32'h50, 1'b0);
        wait_drain(30, "t3_drain");
        chk(out_beats - base == 8, "t3_count", out_beats - base, 8);
        chk(last_out == {1'b1, 32'h57}, "t3_last", last_out, {1'b1, 32'h57});

        // 4: back-to-back 3-beat frames with egress ready toggling
        base = out_beats;
        d0 = drops_seen;
        fork
            begin
                for (int f = 0; f < 4; f++) send_frame(3, 32'h60 + 32'(16 * f), 1'b0);
            end
            begin
                repeat (40) begin
                    m_axis_tready = ~m_axis_tready;
                    @(posedge clk); #1;
                end
            end
        join
        m_axis_tready = 1'b1;
        wait_drain(30, "t4_drain");
        chk(out_beats - base == 12, "t4_count", out_beats - base, 12);
        chk(drops_seen == d0, "t4_no_drop", drops_seen - d0, 0);
        chk(last_out == {1'b1, 32'h92}, "t4_last", last_out, {1'b1, 32'h92});

        // 5: reset during an ingress partial frame and an egress frame
        m_axis_tready = 1'b0;
        base = out_beats;
        send_frame(4, 32'hA0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        cur_drop_exp  = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hB0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        s_axis_tdata = 32'hB1;
        @(posedge clk); #1;
        chk(out_beats - base == 2, "t5_partial_egress", out_beats - base, 2);
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("t5_rst");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk(s_axis_tready == 1'b1, "t5_ready_back", s_axis_tready, 1);
        chk(m_axis_tvalid == 1'b0, "t5_flushed", m_axis_tvalid, 0);
        m_axis_tready = 1'b1;
        base = out_beats;
        send_frame(2, 32'hC0, 1'b0);
        wait_drain(20, "t5_drain");
        chk(out_beats - base == 2, "t5_count", out_beats - base, 2);
        chk(last_out == {1'b1, 32'hC1}, "t5_last", last_out, {1'b1, 32'hC1});

`ifdef FRAME_FIFO_STATS_EN
        // 6: counters since the last reset: three good frames, one overflow
        send_frame(3, 32'hD0, 1'b0);
        send_frame(3, 32'hE0, 1'b0);
        wait_drain(20, "t6_drain");
        send_frame(9, 32'hF0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk(stat_frames_ok == 32'd3, "t6_frames_ok", stat_frames_ok, 3);
        chk(stat_frames_drop == 32'd1, "t6_frames_drop", stat_frames_drop, 1);
`endif

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
